// File: rtl/bch_dec_stream_codec.sv
// bch_dec_stream_codec: streaming DEC BCH parity/syndrome remainder engine with frame-length check.
module bch_dec_stream_codec #(
  parameter int              P_M     = 5,
  parameter int              P_K     = 21,
  parameter int              P_W     = 1,
  parameter logic [2*P_M:0]  P_GPOLY = 11'h769
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode_i,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  input  logic [P_W-1:0]     s_data_i,
  input  logic               s_last_i,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic [2*P_M-1:0]   m_data_o,
  output logic               m_zero_o,
  output logic               m_err_o
);
  localparam int R  = 2 * P_M;
  localparam int B0 = (P_K + P_W - 1) / P_W;
  localparam int B1 = (P_K + R + P_W - 1) / P_W;
  localparam int CW = $clog2(B1 + 2);
  localparam logic [R-1:0] G = P_GPOLY[R-1:0];
  typedef enum logic {ACC, HOLD} state_t;
  state_t        state, state_nxt;
  logic [1:0]    rst_sync;
  logic          rst_q_n;
  logic [R-1:0]  rem, rem_nxt;
  logic [CW-1:0] cnt;
  logic          mode_q, fmode, fire, fb, len_ok;
  // reset asserts asynchronously but is released in step with clk
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  assign rst_q_n = rst_sync[1];
  assign fire    = s_valid_i & s_ready_o;
  assign fmode   = (cnt == '0) ? mode_i : mode_q;
  assign len_ok  = (int'(cnt) + 1) == (fmode ? B1 : B0);
  // parity mode injects data at the feedback tap (x^R premultiply), syndrome mode at the LSB
  always_comb begin
    rem_nxt = rem;
    fb      = 1'b0;
    for (int i = P_W - 1; i >= 0; i--) begin
      fb      = rem_nxt[R-1] ^ (~fmode & s_data_i[i]);
      rem_nxt = {rem_nxt[R-2:0], fmode & s_data_i[i]} ^ ({R{fb}} & G);
    end
  end
  always_ff @(posedge clk or negedge rst_q_n)
    if (!rst_q_n) state <= ACC;
    else          state <= state_nxt;
  always_comb
    state_nxt = (state == ACC) ? ((fire & s_last_i) ? HOLD : ACC) : (m_ready_i ? ACC : HOLD);
  always_comb begin
    s_ready_o = (state == ACC) & rst_q_n;
    m_valid_o = state == HOLD;
  end
  always_ff @(posedge clk or negedge rst_q_n)
    if (!rst_q_n) begin
      rem      <= '0;
      cnt      <= '0;
      mode_q   <= 1'b0;
      m_data_o <= '0;
      m_zero_o <= 1'b0;
      m_err_o  <= 1'b0;
    end else if (fire) begin
      mode_q <= fmode;
      if (s_last_i) begin
        rem      <= '0;
        cnt      <= '0;
        m_data_o <= rem_nxt;
        m_zero_o <= fmode & ~|rem_nxt;
        m_err_o  <= ~len_ok;
      end else begin
        rem <= rem_nxt;
        cnt <= (&cnt) ? cnt : cnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_bch_dec_stream_codec.sv
// tb_bch_dec_stream_codec: directed vector bench driving a 1-bit and a 7-bit wide instance.
module tb_bch_dec_stream_codec;
  logic clk = 0, rst_n = 1, sel = 0, valid = 0, last = 0, mode = 0, mrdy = 0;
  logic [6:0] dat = '0;
  logic sr1, mv1, mz1, me1, sr7, mv7, mz7, me7;
  logic [9:0] md1, md7;
  logic sr, mv, mz, me;
  logic [9:0] md;
  int checks = 0, failures = 0;

  typedef struct {
    bit          w7;
    bit          m;
    int          n;
    logic [34:0] data;
    logic [9:0]  ed;
    bit          ez;
    bit          ee;
  } vec_t;
  vec_t tv[14];

  always #5 clk = ~clk;

  bch_dec_stream_codec #(.P_W(1)) u1 (
    .clk(clk), .rst_n(rst_n), .mode_i(mode), .s_valid_i(valid & ~sel), .s_ready_o(sr1),
    .s_data_i(dat[0]), .s_last_i(last), .m_valid_o(mv1), .m_ready_i(mrdy & ~sel),
    .m_data_o(md1), .m_zero_o(mz1), .m_err_o(me1));
  bch_dec_stream_codec #(.P_W(7)) u7 (
    .clk(clk), .rst_n(rst_n), .mode_i(mode), .s_valid_i(valid & sel), .s_ready_o(sr7),
    .s_data_i(dat), .s_last_i(last), .m_valid_o(mv7), .m_ready_i(mrdy & sel),
    .m_data_o(md7), .m_zero_o(mz7), .m_err_o(me7));

  assign sr = sel ? sr7 : sr1;
  assign mv = sel ? mv7 : mv1;
  assign md = sel ? md7 : md1;
  assign mz = sel ? mz7 : mz1;
  assign me = sel ? me7 : me1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input string nm);
    int k = 0;
    while (sr !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " ready"}, 32'(sr), 1);
  endtask

  // mode_i is inverted after the first beat to show it is only sampled once
  task automatic send(input bit w7, input bit m, input int n, input logic [34:0] data);
    sel = w7;
    for (int i = 0; i < n; i++) begin
      valid = 1;
      last  = (i == n - 1);
      mode  = (i == 0) ? m : ~m;
      dat   = w7 ? 7'((data >> (7 * (n - 1 - i))) & 35'h7F) : {6'b0, data[n-1-i]};
      if (i == n - 1) chk("no early valid", 32'(mv), 0);
      @(negedge clk);
    end
    valid = 0;
    last  = 0;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    sel = v.w7;
    wait_ready(nm);
    send(v.w7, v.m, v.n, v.data);
    chk({nm, " valid"}, 32'(mv), 1);
    chk({nm, " data"}, 32'(md), 32'(v.ed));
    chk({nm, " zero"}, 32'(mz), 32'(v.ez));
    chk({nm, " err"}, 32'(me), 32'(v.ee));
    mrdy = 1;
    @(negedge clk);
    mrdy = 0;
    chk({nm, " valid drop"}, 32'(mv), 0);
    chk({nm, " ready back"}, 32'(sr), 1);
  endtask

  initial begin
    tv[0]  = '{0, 0, 21, 35'h1,   10'h369, 0, 0};
    tv[1]  = '{0, 1, 31, 35'h769, 10'h000, 1, 0};
    tv[2]  = '{0, 1, 31, 35'h768, 10'h001, 0, 0};
    tv[3]  = '{0, 0, 21, 35'h2,   10'h1BB, 0, 0};
    tv[4]  = '{0, 1, 31, 35'h9BB, 10'h000, 1, 0};
    tv[5]  = '{1, 0, 3,  35'h1,   10'h369, 0, 0};
    tv[6]  = '{1, 0, 3,  35'h0,   10'h000, 0, 0};
    tv[7]  = '{1, 1, 5,  35'h769, 10'h000, 1, 0};
    tv[8]  = '{1, 1, 5,  35'h768, 10'h001, 0, 0};
    tv[9]  = '{1, 0, 2,  35'h1,   10'h369, 0, 1};
    tv[10] = '{1, 0, 5,  35'h1,   10'h369, 0, 1};
    tv[11] = '{1, 0, 3,  35'h1,   10'h369, 0, 0};
    tv[12] = '{0, 0, 5,  35'h1,   10'h369, 0, 1};
    tv[13] = '{0, 0, 31, 35'h1,   10'h369, 0, 1};

    #1 rst_n = 0;
    #2;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #0;
      chk("rst valid", 32'(mv), 0);
      chk("rst data", 32'(md), 0);
      chk("rst zero", 32'(mz), 0);
      chk("rst err", 32'(me), 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 14; i++) run_vec($sformatf("vec%0d", i), tv[i]);

    // backpressure: result held, new beat refused
    sel = 1;
    wait_ready("bp");
    send(1, 0, 3, 35'h1);
    for (int k = 0; k < 5; k++) begin
      valid = 1;
      last  = 1;
      dat   = 7'h7F;
      @(negedge clk);
      chk("bp valid", 32'(mv), 1);
      chk("bp data", 32'(md), 32'h369);
      chk("bp ready", 32'(sr), 0);
    end
    valid = 0;
    last  = 0;
    mrdy  = 1;
    @(negedge clk);
    mrdy = 0;
    chk("bp release valid", 32'(mv), 0);
    chk("bp release ready", 32'(sr), 1);
    run_vec("bp next", tv[6]);

    // reset mid-frame on the 1-bit instance
    run_vec("pre rst", tv[0]);
    sel = 0;
    for (int i = 0; i < 10; i++) begin
      valid = 1;
      last  = 0;
      mode  = 0;
      dat   = 7'h01;
      @(negedge clk);
    end
    valid = 0;
    #2 rst_n = 0;
    #1;
    chk("mid rst valid", 32'(mv), 0);
    chk("mid rst data", 32'(md), 0);
    chk("mid rst zero", 32'(mz), 0);
    chk("mid rst err", 32'(me), 0);
    @(negedge clk);
    rst_n = 1;
    run_vec("post rst", tv[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
